// File: rtl/ozixe_cell_pkg.sv
// rtl/ozixe_cell_pkg.sv - shared types, mode-word layout and sizing helpers for the ozixe logic cell
package ozixe_cell_pkg;

  // Mode-word field positions
  localparam int CEMUX_LSB   = 0;
  localparam int CEMUX_MSB   = 1;
  localparam int REGSET_BIT  = 2;
  localparam int SRMODE_BIT  = 3;
  localparam int LSRMODE_BIT = 4;

  // Clock-enable mux selection; RSV behaves like ONE but flags the config as malformed
  typedef enum logic [1:0] {
    CEMUX_ONE = 2'd0,
    CEMUX_CE  = 2'd1,
    CEMUX_INV = 2'd2,
    CEMUX_RSV = 2'd3
  } cemux_e;

  typedef enum logic {
    REGSET_RESET = 1'b0,
    REGSET_SET   = 1'b1
  } regset_e;

  typedef enum logic {
    SRMODE_LSR_OVER_CE = 1'b0,
    SRMODE_ASYNC       = 1'b1
  } srmode_e;

  typedef enum logic {
    LSRMODE_LSR  = 1'b0,
    LSRMODE_PRLD = 1'b1
  } lsrmode_e;

  typedef struct packed {
    lsrmode_e lsrmode;
    srmode_e  srmode;
    regset_e  regset;
    cemux_e   cemux;
  } mode_t;

  typedef enum logic [1:0] {
    ST_UNCONF    = 2'd0,
    ST_LOAD_INIT = 2'd1,
    ST_READY     = 2'd2
  } state_e;

  // Number of 32-bit config words holding a 2^k-bit INIT
  function automatic int init_words(input int k);
    return (1 << k) / 32;
  endfunction

endpackage

// File: rtl/ozixe_lut_ram.sv
// rtl/ozixe_lut_ram.sv - synchronous 32-bit wide INIT store, one write port and one read port
module ozixe_lut_ram #(
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Config-time write of one INIT word
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Evaluation read; output holds between reads
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ozixe_lut16_cell.sv
// rtl/ozixe_lut16_cell.sv - LUT16 plus TRELLIS_FF-style register with streamed configuration
module ozixe_lut16_cell
  import ozixe_cell_pkg::*;
#(
  parameter int LUT_K = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [31:0] cfg_data,
  input  logic        cfg_last,
  output logic        cfg_err,
  output logic        configured,
  input  logic        in_valid,
  input  logic [15:0] I,
  input  logic        CE,
  input  logic        LSR,
  input  logic        M,
  input  logic        DI_SEL,
  output logic        O,
  output logic        o_valid,
  output logic        Q,
  output logic        drop
);

  localparam int INIT_WORDS = init_words(LUT_K);
  localparam int AW = (LUT_K > 5) ? LUT_K - 5 : 1;
  localparam logic [AW-1:0] LAST_WORD = AW'(INIT_WORDS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          err_q, err_d;
  mode_t         mode_q, mode_d;
  mode_t         mode_word;
  logic          ram_we;
  logic          cfg_accept;
  logic          eval_fire;

  logic [AW-1:0] rd_addr;
  logic [31:0]   ram_rdata;

  // Beat registers for the cycle after in_valid
  logic          v1_q;
  logic [4:0]    sel_q;
  logic          ce_q, lsr_q, m_q, di_sel_q;
  logic          o_hold_q;
  logic          drop_q;
  logic          q_q;

  logic          lut_o;
  logic          ce_eff;
  logic          d_ff;
  logic          lsr_val;

  // The RAM write needs no wait states, so the config port never stalls
  assign cfg_ready  = 1'b1;
  assign cfg_accept = cfg_valid & cfg_ready;
  // Config traffic wins over an evaluation beat in the same cycle
  assign eval_fire  = in_valid & (state_q == ST_READY) & ~cfg_accept;

  assign mode_word.cemux   = cemux_e'(cfg_data[CEMUX_MSB:CEMUX_LSB]);
  assign mode_word.regset  = regset_e'(cfg_data[REGSET_BIT]);
  assign mode_word.srmode  = srmode_e'(cfg_data[SRMODE_BIT]);
  assign mode_word.lsrmode = lsrmode_e'(cfg_data[LSRMODE_BIT]);

  if (LUT_K > 5) begin : g_addr_wide
    assign rd_addr = I[LUT_K-1:5];
  end else begin : g_addr_single
    assign rd_addr = '0;
  end

  ozixe_lut_ram #(
    .DEPTH (INIT_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (wcnt_q),
    .wdata (cfg_data),
    .re    (eval_fire),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Config FSM state, word counter, sticky error and mode register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_UNCONF;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      mode_q  <= mode_d;
    end
  end

  // Config FSM next state: first word is the mode word, then INIT_WORDS words framed by cfg_last
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    mode_d  = mode_q;
    ram_we  = 1'b0;
    if (cfg_accept) begin
      case (state_q)
        ST_LOAD_INIT: begin
          ram_we = 1'b1;
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_q == LAST_WORD) begin
            if (cfg_last) begin
              state_d = ST_READY;
            end else begin
              err_d   = 1'b1;
              state_d = ST_UNCONF;
            end
          end else if (cfg_last) begin
            err_d   = 1'b1;
            state_d = ST_UNCONF;
          end
        end
        default: begin
          wcnt_d = '0;
          if (cfg_last) begin
            err_d   = 1'b1;
            state_d = ST_UNCONF;
          end else begin
            err_d   = (mode_word.cemux == CEMUX_RSV);
            mode_d  = mode_word;
            state_d = ST_LOAD_INIT;
          end
        end
      endcase
    end
  end

  // Capture an accepted beat's control inputs for the FF update one cycle later
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v1_q     <= 1'b0;
      sel_q    <= '0;
      ce_q     <= 1'b0;
      lsr_q    <= 1'b0;
      m_q      <= 1'b0;
      di_sel_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      v1_q   <= eval_fire;
      drop_q <= in_valid & ~eval_fire;
      if (eval_fire) begin
        sel_q    <= I[4:0];
        ce_q     <= CE;
        lsr_q    <= LSR;
        m_q      <= M;
        di_sel_q <= DI_SEL;
      end
    end
  end

  assign lut_o = ram_rdata[sel_q];

  // O keeps its last evaluated value through idle cycles
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) o_hold_q <= 1'b0;
    else if (v1_q) o_hold_q <= lut_o;
  end

  // Effective clock enable from the CE mux; reserved encoding acts as always-on
  always_comb begin
    ce_eff = 1'b1;
    case (mode_q.cemux)
      CEMUX_CE:  ce_eff = ce_q;
      CEMUX_INV: ce_eff = ~ce_q;
      default:   ce_eff = 1'b1;
    endcase
  end

  assign d_ff    = di_sel_q ? m_q : lut_o;
  assign lsr_val = (mode_q.lsrmode == LSRMODE_PRLD) ? m_q : mode_q.regset;

  // Cell flip-flop: LSR overrides CE, otherwise load D when enabled
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_q <= 1'b0;
    end else if (v1_q) begin
      if (lsr_q) q_q <= lsr_val;
      else if (ce_eff) q_q <= d_ff;
    end
  end

  assign O          = v1_q ? lut_o : o_hold_q;
  assign o_valid    = v1_q;
  // In ASYNC mode an active LSR shows on Q during the beat's output cycle
  assign Q          = (v1_q && lsr_q && mode_q.srmode == SRMODE_ASYNC) ? lsr_val : q_q;
  assign drop       = drop_q;
  assign cfg_err    = err_q;
  assign configured = (state_q == ST_READY);

endmodule

// File: tb/tb_ozixe_lut16_cell.sv
// tb/tb_ozixe_lut16_cell.sv - directed self-checking bench with a behavioural cell model
module tb_ozixe_lut16_cell;

  logic        CLK;
  logic        RST_N;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;
  logic        cfg_last;
  logic        cfg_err;
  logic        configured;
  logic        in_valid;
  logic [15:0] I;
  logic        CE, LSR, M, DI_SEL;
  logic        O, o_valid, Q, drop;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  ozixe_lut16_cell dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .cfg_last   (cfg_last),
    .cfg_err    (cfg_err),
    .configured (configured),
    .in_valid   (in_valid),
    .I          (I),
    .CE         (CE),
    .LSR        (LSR),
    .M          (M),
    .DI_SEL     (DI_SEL),
    .O          (O),
    .o_valid    (o_valid),
    .Q          (Q),
    .drop       (drop)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: INIT as a flat bit array indexed by I
  bit       m_init [65536];
  int       m_state;  // 0 unconfigured, 1 loading, 2 ready
  int       m_cnt;
  bit       m_err;
  bit [4:0] m_mode;   // {lsrmode, srmode, regset, cemux[1:0]}
  bit       exp_ov, exp_o, exp_drop, m_q;
  bit       b_ce, b_lsr, b_m, b_di;
  bit       mdl_fire, mdl_en;

  initial forever begin
    @(posedge CLK or negedge RST_N);
    if (!RST_N) begin
      m_state = 0; m_cnt = 0; m_err = 0; m_mode = '0;
      exp_ov = 0; exp_o = 0; exp_drop = 0; m_q = 0;
      b_ce = 0; b_lsr = 0; b_m = 0; b_di = 0;
    end else begin
      // Finish the beat currently in its output cycle
      if (exp_ov) begin
        if (b_lsr) begin
          m_q = m_mode[4] ? b_m : m_mode[2];
        end else begin
          mdl_en = (m_mode[1:0] == 2'd1) ? b_ce : (m_mode[1:0] == 2'd2) ? !b_ce : 1'b1;
          if (mdl_en) m_q = b_di ? b_m : exp_o;
        end
      end
      mdl_fire = in_valid && (m_state == 2) && !cfg_valid;
      exp_drop = in_valid && !mdl_fire;
      exp_ov   = mdl_fire;
      if (mdl_fire) begin
        exp_o = m_init[I];
        b_ce = CE; b_lsr = LSR; b_m = M; b_di = DI_SEL;
      end
      if (cfg_valid) begin
        if (m_state != 1) begin
          m_cnt = 0;
          if (cfg_last) begin
            m_err = 1; m_state = 0;
          end else begin
            m_err = (cfg_data[1:0] == 2'd3);
            m_mode = cfg_data[4:0];
            m_state = 1;
          end
        end else begin
          for (int b = 0; b < 32; b++) m_init[m_cnt*32 + b] = cfg_data[b];
          if (m_cnt == 2047) begin
            if (cfg_last) m_state = 2;
            else begin m_err = 1; m_state = 0; end
          end else if (cfg_last) begin
            m_err = 1; m_state = 0;
          end
          m_cnt++;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  initial forever begin
    @(negedge CLK);
    if (chk_en && RST_N) begin
      chk("cmp_cfg_ready", cfg_ready, 1'b1);
      chk("cmp_configured", configured, m_state == 2);
      chk("cmp_cfg_err", cfg_err, m_err);
      chk("cmp_o_valid", o_valid, exp_ov);
      chk("cmp_o", O, exp_o);
      chk("cmp_q", Q, (exp_ov && b_lsr && m_mode[3]) ? (m_mode[4] ? b_m : m_mode[2]) : m_q);
      chk("cmp_drop", drop, exp_drop);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    cfg_valid = 1'b1; cfg_data = d; cfg_last = last;
    tick();
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  function automatic logic [31:0] word_of(input int kind, input int w);
    if (kind == 1) return 32'hFFFF_FFFF;
    return (w == 2047) ? 32'h8000_0000 : 32'h0;
  endfunction

  task automatic load(input logic [31:0] mode, input int kind, input int last_at);
    send_word(mode, 1'b0);
    for (int w = 0; w <= last_at; w++) send_word(word_of(kind, w), w == last_at);
  endtask

  task automatic beat(input logic [15:0] i, input logic ce, input logic lsr,
                      input logic m, input logic di);
    in_valid = 1'b1; I = i; CE = ce; LSR = lsr; M = m; DI_SEL = di;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; cfg_valid = 0; cfg_data = '0; cfg_last = 0;
    in_valid = 0; I = '0; CE = 0; LSR = 0; M = 0; DI_SEL = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    chk("rst_configured", configured, 1'b0);
    chk("rst_o", O, 1'b0);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_q", Q, 1'b0);
    chk("rst_drop", drop, 1'b0);
    RST_N = 1'b1;
    chk_en = 1'b1;

    // Only INIT[65535] set, CEMUX "1"
    load(32'h00, 0, 2047);
    chk("t1_configured", configured, 1'b1);
    beat(16'hFFFF, 0, 0, 0, 0);
    chk("t1_o_c1", O, 1'b1);
    chk("t1_ov_c1", o_valid, 1'b1);
    beat(16'hFFFE, 0, 0, 0, 0);
    chk("t1_o_c2", O, 1'b0);
    chk("t1_q_c2", Q, 1'b1);
    tick();
    chk("t1_q_c3", Q, 1'b0);
    chk("t1_ov_c3", o_valid, 1'b0);

    // Inverted CE, all-ones INIT
    load(32'h02, 1, 2047);
    beat(16'h1234, 1, 0, 0, 0);
    chk("t2_o", O, 1'b1);
    tick();
    chk("t2_q_hold", Q, 1'b0);
    beat(16'h1234, 0, 0, 0, 0);
    tick();
    chk("t2_q_set", Q, 1'b1);

    // CE mux, SET, LSR over CE
    load(32'h05, 1, 2047);
    beat(16'h0000, 1, 0, 0, 1);
    tick();
    chk("t3_q_clear", Q, 1'b0);
    beat(16'h0000, 0, 1, 0, 0);
    chk("t3_o_unaffected", O, 1'b1);
    chk("t3_q_c1", Q, 1'b0);
    tick();
    chk("t3_q_c2", Q, 1'b1);

    // ASYNC reset, then ASYNC preload
    load(32'h08, 1, 2047);
    beat(16'h0000, 0, 1, 0, 0);
    chk("t4_q_async_c1", Q, 1'b0);
    tick();
    chk("t4_q_async_c2", Q, 1'b0);
    load(32'h18, 1, 2047);
    beat(16'h0000, 0, 1, 1, 0);
    chk("t4_q_prld_c1", Q, 1'b1);
    tick();
    chk("t4_q_prld_c2", Q, 1'b1);

    // Early cfg_last on INIT word 100
    load(32'h00, 0, 100);
    chk("t5_err", cfg_err, 1'b1);
    chk("t5_unconf", configured, 1'b0);
    beat(16'hFFFF, 0, 0, 0, 0);
    chk("t5_drop", drop, 1'b1);
    chk("t5_no_ov", o_valid, 1'b0);
    load(32'h00, 0, 2047);
    chk("t5_err_clear", cfg_err, 1'b0);
    chk("t5_reconf", configured, 1'b1);
    beat(16'hFFFF, 0, 0, 0, 0);
    chk("t5_o", O, 1'b1);
    tick();
    chk("t5_q", Q, 1'b1);

    // Beat collides with a mode word, then reset mid-load
    in_valid = 1'b1; I = 16'hFFFF;
    send_word(32'h00, 1'b0);
    in_valid = 1'b0;
    chk("t6_collide_drop", drop, 1'b1);
    chk("t6_collide_conf", configured, 1'b0);
    for (int w = 0; w < 1000; w++) send_word(word_of(0, w), 1'b0);
    RST_N = 1'b0;
    #1;
    chk("t6_rst_conf", configured, 1'b0);
    chk("t6_rst_q", Q, 1'b0);
    chk("t6_rst_ready", cfg_ready, 1'b1);
    #1;
    RST_N = 1'b1;
    // Reserved CEMUX: flagged but the load completes
    load(32'h03, 0, 2047);
    chk("t6_rsv_conf", configured, 1'b1);
    chk("t6_rsv_err", cfg_err, 1'b1);
    beat(16'hFFFF, 0, 0, 0, 0);
    chk("t6_o", O, 1'b1);
    tick();
    chk("t6_q", Q, 1'b1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
